// File: rtl/if_stage_pkg.sv
// Shared types and helpers for the instruction-fetch stage and its instruction buffer.
package if_stage_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] npc;
   } IF_PACKET;

   // Redirect targets are word-aligned by dropping the two low bits.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

   function automatic IF_PACKET make_packet(input logic [XLEN-1:0] inst,
                                            input logic [XLEN-1:0] pc);
      IF_PACKET p;
      p.inst = inst;
      p.pc   = pc;
      p.npc  = pc + PC_STEP;
      return p;
   endfunction

endpackage

// File: rtl/if_stage_inst_buffer.sv
// Circular FIFO of IF_PACKET entries with push, pop, flush, full/empty and occupancy count.
module inst_buffer
   import if_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  IF_PACKET                   i_data,
   output IF_PACKET                   o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   IF_PACKET        r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_push_ok;
   logic            w_pop_ok;

   assign o_full    = (r_count == CNT_MAX);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];

   // A full buffer refuses pushes even when a pop happens in the same cycle.
   assign w_push_ok = i_push && !o_full  && !i_flush;
   assign w_pop_ok  = i_pop  && !o_empty && !i_flush;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         unique case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; an entry is only read after a push has written it.
   always_ff @(posedge clock) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: owns the fetch PC, buffers icache hits and hands in-order packets to decode.
// Optional same-cycle bypass of an empty buffer is enabled by defining IF_BYPASS_EN.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int unsigned     IBUF_DEPTH = 8,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [XLEN-1:0]               Icache2proc_data,
   input  logic                          Icache2proc_valid,
   input  logic                          commit_mis_pred,
   input  logic [XLEN-1:0]               commit_target_pc,
   input  logic                          id_ready,
   output logic [XLEN-1:0]               proc2Icache_addr,
   output logic                          if_valid,
   output IF_PACKET                      if_packet,
   output logic [$clog2(IBUF_DEPTH):0]   ibuf_count
);

   logic [XLEN-1:0] r_pc;

   IF_PACKET w_fetch_pkt;
   IF_PACKET w_head;
   logic     w_full;
   logic     w_empty;
   logic     w_hit_ok;
   logic     w_fetch_adv;
   logic     w_head_valid;
   logic     w_bypass;
   logic     w_push;
   logic     w_pop;

   assign proc2Icache_addr = r_pc;
   assign w_fetch_pkt      = make_packet(Icache2proc_data, r_pc);

   // A redirect discards this cycle's hit and hides the buffer head from decode.
   assign w_hit_ok     = Icache2proc_valid && !commit_mis_pred;
   assign w_fetch_adv  = w_hit_ok && !w_full;
   assign w_head_valid = !w_empty && !commit_mis_pred;
   assign w_pop        = w_head_valid && id_ready;

`ifdef IF_BYPASS_EN
   // The bypassed hit is consumed directly when decode is ready, otherwise buffered.
   assign w_bypass = w_empty && w_hit_ok && !reset;
   assign w_push   = w_fetch_adv && !(w_bypass && id_ready);
`else
   assign w_bypass = 1'b0;
   assign w_push   = w_fetch_adv;
`endif

   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      if_valid  = 1'b0;
      if_packet = '0;
      if (w_head_valid) begin
         if_valid  = 1'b1;
         if_packet = w_head;
      end else if (w_bypass) begin
         if_valid  = 1'b1;
         if_packet = w_fetch_pkt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (commit_mis_pred) begin
         r_pc <= align_pc(commit_target_pc);
      end else if (w_fetch_adv) begin
         r_pc <= r_pc + PC_STEP;
      end
   end

   inst_buffer #(
      .DEPTH (IBUF_DEPTH)
   ) u_inst_buffer (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (commit_mis_pred),
      .i_data  (w_fetch_pkt),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (ibuf_count)
   );

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; the icache model returns the bitwise inverse of the address.
module tb_if_stage;
   import if_stage_pkg::*;

   logic            clk;
   logic            rst;
   logic [XLEN-1:0] icache_data;
   logic            icache_valid;
   logic            mis_pred;
   logic [XLEN-1:0] target_pc;
   logic            id_ready;
   logic [XLEN-1:0] addr;
   logic            if_valid;
   IF_PACKET        pkt;
   logic [3:0]      count;

   int errors = 0;
   int checks = 0;

   if_stage #(
      .IBUF_DEPTH (8),
      .RESET_PC   (32'h0)
   ) dut (
      .clock             (clk),
      .reset             (rst),
      .Icache2proc_data  (icache_data),
      .Icache2proc_valid (icache_valid),
      .commit_mis_pred   (mis_pred),
      .commit_target_pc  (target_pc),
      .id_ready          (id_ready),
      .proc2Icache_addr  (addr),
      .if_valid          (if_valid),
      .if_packet         (pkt),
      .ibuf_count        (count)
   );

   assign icache_data = ~addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      icache_valid = 1'b0;
      mis_pred     = 1'b0;
      target_pc    = '0;
      id_ready     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", addr, 32'h0); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
      checks++; if (pkt !== '0) begin errors++; $display("FAIL reset_packet: got %h want 0", pkt); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
   endtask

   task automatic test_stream();
      logic [XLEN-1:0] exp_pc;
      do_reset();
      icache_valid = 1'b1;
      id_ready     = 1'b1;
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", if_valid); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp_pc = 32'(4 * (k - 1));
         checks++; if (addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr k=%0d: got %h want %h", k, addr, 32'(4 * k)); end
         checks++; if (if_valid !== 1'b1 || pkt.pc !== exp_pc || pkt.npc !== exp_pc + 32'd4 || pkt.inst !== ~exp_pc)
            begin errors++; $display("FAIL stream_pkt k=%0d: got v=%b %h want pc %h", k, if_valid, pkt, exp_pc); end
         checks++; if (count !== 4'd1) begin errors++; $display("FAIL stream_count k=%0d: got %0d want 1", k, count); end
      end
   endtask

   task automatic test_full();
      do_reset();
      icache_valid = 1'b1;
      id_ready     = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++; if (count !== 4'(k > 8 ? 8 : k)) begin errors++; $display("FAIL full_count k=%0d: got %0d want %0d", k, count, (k > 8 ? 8 : k)); end
      end
      checks++; if (addr !== 32'h20) begin errors++; $display("FAIL full_addr_hold: got %h want 20", addr); end
      checks++; if (pkt.pc !== 32'h0) begin errors++; $display("FAIL full_head: got %h want 0", pkt.pc); end
      id_ready = 1'b1;
      tick();
      checks++; if (count !== 4'd7 || addr !== 32'h20 || pkt.pc !== 32'h4)
         begin errors++; $display("FAIL full_no_popthrough: got cnt=%0d addr=%h pc=%h want 7 20 4", count, addr, pkt.pc); end
      tick();
      checks++; if (count !== 4'd7 || addr !== 32'h24 || pkt.pc !== 32'h8)
         begin errors++; $display("FAIL full_resume: got cnt=%0d addr=%h pc=%h want 7 24 8", count, addr, pkt.pc); end
      icache_valid = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         checks++; if (count !== 4'(7 - i)) begin errors++; $display("FAIL drain_count i=%0d: got %0d want %0d", i, count, 7 - i); end
         if (i < 7) begin
            checks++; if (if_valid !== 1'b1 || pkt.pc !== 32'(8 + 4 * i))
               begin errors++; $display("FAIL drain_order i=%0d: got v=%b pc=%h want %h", i, if_valid, pkt.pc, 32'(8 + 4 * i)); end
         end else begin
            checks++; if (if_valid !== 1'b0 || pkt !== '0) begin errors++; $display("FAIL drain_empty: got v=%b pkt=%h want 0", if_valid, pkt); end
         end
      end
   endtask

   task automatic test_miss();
      do_reset();
      icache_valid = 1'b1;
      id_ready     = 1'b1;
      repeat (16) tick();
      checks++; if (addr !== 32'h40) begin errors++; $display("FAIL miss_setup_addr: got %h want 40", addr); end
      icache_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (addr !== 32'h40 || count !== 4'd0)
            begin errors++; $display("FAIL miss_hold i=%0d: got addr=%h cnt=%0d want 40 0", i, addr, count); end
      end
      icache_valid = 1'b1;
      tick();
      checks++; if (addr !== 32'h44 || count !== 4'd1 || pkt.pc !== 32'h40 || pkt.npc !== 32'h44 || pkt.inst !== ~32'h40)
         begin errors++; $display("FAIL miss_refill: got addr=%h cnt=%0d pkt=%h want 44 1 pc 40", addr, count, pkt); end
   endtask

   task automatic test_redirect();
      do_reset();
      icache_valid = 1'b1;
      id_ready     = 1'b0;
      repeat (3) tick();
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL redir_setup_count: got %0d want 3", count); end
      mis_pred  = 1'b1;
      target_pc = 32'h1003;
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_forced: got %b want 0", if_valid); end
      tick();
      mis_pred = 1'b0;
      #1;
      checks++; if (count !== 4'd0 || if_valid !== 1'b0 || addr !== 32'h1000)
         begin errors++; $display("FAIL redir_flush: got cnt=%0d v=%b addr=%h want 0 0 1000", count, if_valid, addr); end
      tick();
      checks++; if (if_valid !== 1'b1 || pkt.pc !== 32'h1000 || pkt.npc !== 32'h1004 || count !== 4'd1)
         begin errors++; $display("FAIL redir_first_pkt: got v=%b pkt=%h cnt=%0d want pc 1000", if_valid, pkt, count); end
   endtask

   task automatic test_redirect_pop_hit();
      do_reset();
      icache_valid = 1'b1;
      id_ready     = 1'b1;
      repeat (2) tick();
      checks++; if (count !== 4'd1 || pkt.pc !== 32'h4) begin errors++; $display("FAIL rph_setup: got cnt=%0d pc=%h want 1 4", count, pkt.pc); end
      mis_pred  = 1'b1;
      target_pc = 32'h2000;
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rph_no_pop: got %b want 0", if_valid); end
      tick();
      mis_pred = 1'b0;
      icache_valid = 1'b0;
      #1;
      checks++; if (count !== 4'd0 || addr !== 32'h2000 || if_valid !== 1'b0)
         begin errors++; $display("FAIL rph_discard: got cnt=%0d addr=%h v=%b want 0 2000 0", count, addr, if_valid); end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      mis_pred  = 1'b1;
      target_pc = 32'hFFFF_FFFE;
      tick();
      mis_pred = 1'b0;
      checks++; if (addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want fffffffc", addr); end
      icache_valid = 1'b1;
      tick();
      checks++; if (addr !== 32'h0 || pkt.pc !== 32'hFFFF_FFFC || pkt.npc !== 32'h0)
         begin errors++; $display("FAIL wrap_pc: got addr=%h pkt=%h want 0 pc fffffffc npc 0", addr, pkt); end
   endtask

   task automatic test_async_reset();
      do_reset();
      icache_valid = 1'b1;
      repeat (3) tick();
      #2;
      rst = 1'b1;
      #1;
      checks++; if (count !== 4'd0 || addr !== 32'h0 || if_valid !== 1'b0 || pkt !== '0)
         begin errors++; $display("FAIL async_reset: got cnt=%0d addr=%h v=%b pkt=%h want all 0", count, addr, if_valid, pkt); end
      rst = 1'b0;
   endtask

   task automatic test_bypass();
      do_reset();
      icache_valid = 1'b1;
      id_ready     = 1'b1;
      #1;
`ifdef IF_BYPASS_EN
      checks++; if (if_valid !== 1'b1 || pkt.pc !== 32'h0 || count !== 4'd0)
         begin errors++; $display("FAIL bypass_same_cycle: got v=%b pc=%h cnt=%0d want 1 0 0", if_valid, pkt.pc, count); end
      tick();
      checks++; if (count !== 4'd0 || addr !== 32'h4) begin errors++; $display("FAIL bypass_consumed: got cnt=%0d addr=%h want 0 4", count, addr); end
`else
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle: got v=%b want 0", if_valid); end
      tick();
      checks++; if (if_valid !== 1'b1 || pkt.pc !== 32'h0 || count !== 4'd1)
         begin errors++; $display("FAIL nobypass_next_cycle: got v=%b pc=%h cnt=%0d want 1 0 1", if_valid, pkt.pc, count); end
`endif
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_miss();
      test_redirect();
      test_redirect_pop_hit();
      test_pc_wrap();
      test_async_reset();
      test_bypass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
